// File: rtl/mem_access_seq.sv
// MAR/MDR memory-path sequencer: one request -> address load, data load, strobe/ready handshake, done.
// Read/write take 4+ cycles from start to done; a start is only taken in IDLE, and mem_ready is the only stall.
module mem_access_seq #(
    parameter int unsigned MIN_WAIT = 1,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic start_rd,
    input  logic start_wr,
    input  logic mem_ready,
    output logic MARin,
    output logic MDRin,
    output logic read,
    output logic MDRout,
    output logic mem_rd,
    output logic mem_wr,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_MEM   = 3'd3,
        S_CAPT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [8:0] MIN_W9   = 9'(MIN_WAIT);

    state_t     state_q, state_d;
    logic       op_rd_q, op_rd_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wait_ok;
    logic       cnt_last;

    // cnt >= MIN_WAIT written as cnt+1 > MIN_WAIT so MIN_WAIT=0 is not a constant compare
    assign wait_ok  = ({1'b0, cnt_q} + 9'd1) > MIN_W9;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        op_rd_d = op_rd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_rd) begin
                    state_d = S_ADDR;
                    op_rd_d = 1'b1;
                end else if (start_wr) begin
                    state_d = S_ADDR;
                    op_rd_d = 1'b0;
                end
            end
            S_ADDR: begin
                state_d = op_rd_q ? S_MEM : S_WDATA;
                cnt_d   = '0;
            end
            S_WDATA: begin
                state_d = S_MEM;
                cnt_d   = '0;
            end
            S_MEM: begin
                cnt_d = cnt_q + 8'd1;
                // a qualified ready on the last allowed cycle still completes normally
                if (mem_ready && wait_ok) begin
                    state_d = op_rd_q ? S_CAPT : S_DONE;
                end else if (cnt_last) begin
                    state_d = S_ERR;
                end
            end
            S_CAPT:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= S_IDLE;
            op_rd_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_rd_q <= op_rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore decode straight off the state register
    always_comb begin
        MARin  = 1'b0;
        MDRin  = 1'b0;
        read   = 1'b0;
        MDRout = 1'b0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        busy   = (state_q != S_IDLE);
        done   = 1'b0;
        err    = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_ADDR:  MARin = 1'b1;
            S_WDATA: MDRin = 1'b1;
            S_MEM: begin
                mem_rd = op_rd_q;
                mem_wr = !op_rd_q;
            end
            S_CAPT: begin
                MDRin = 1'b1;
                read  = 1'b1;
            end
            S_DONE: begin
                done   = 1'b1;
                MDRout = op_rd_q;
            end
            S_ERR: begin
                done = 1'b1;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: per-cycle expected output vectors queued at stimulus time, compared each cycle.
module tb_mem_access_seq;

    localparam int MW = 1;
    localparam int TO = 16;

    // bit order: MARin MDRin read MDRout mem_rd mem_wr busy done err
    localparam logic [8:0] O_IDLE  = 9'b000000000;
    localparam logic [8:0] O_ADDR  = 9'b100000100;
    localparam logic [8:0] O_WDATA = 9'b010000100;
    localparam logic [8:0] O_MEMR  = 9'b000010100;
    localparam logic [8:0] O_MEMW  = 9'b000001100;
    localparam logic [8:0] O_CAPT  = 9'b011000100;
    localparam logic [8:0] O_DONER = 9'b000100110;
    localparam logic [8:0] O_DONEW = 9'b000000110;
    localparam logic [8:0] O_ERR   = 9'b000000111;

    logic clk = 1'b0;
    logic clr, start_rd, start_wr, mem_ready;
    logic MARin, MDRin, read, MDRout, mem_rd, mem_wr, busy, done, err;

    int total = 0;
    int bad   = 0;
    logic       mon_en = 1'b0;
    logic [8:0] exp_q[$];

    mem_access_seq #(.MIN_WAIT(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .start_rd(start_rd), .start_wr(start_wr),
        .mem_ready(mem_ready), .MARin(MARin), .MDRin(MDRin), .read(read),
        .MDRout(MDRout), .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: one expected vector per cycle; an empty queue means the block must be idle
    always @(negedge clk) begin
        if (mon_en) begin
            logic [8:0] e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : O_IDLE;
            check("out", {MARin, MDRin, read, MDRout, mem_rd, mem_wr, busy, done, err}, e);
        end
    end

    // rd/wr: start pulses; rdy_at: MEM cycle index from which mem_ready stays high (-1 never)
    // wr_mem: MEM index at which a stray start_wr is pulsed (-1 none); rst_at: MEM index of clr=0 (-1 none)
    task automatic run_xfer(input bit rd, input bit wr, input int rdy_at, input int wr_mem, input int rst_at);
        bit is_rd;
        int base, c, n_mem, len;
        bit ok;
        is_rd = rd;
        base  = is_rd ? 2 : 3;
        c     = (rdy_at > MW) ? rdy_at : MW;
        ok    = (rdy_at >= 0) && (c <= TO - 1);
        n_mem = ok ? c + 1 : TO;
        if (rst_at >= 0) n_mem = rst_at + 1;

        exp_q.push_back(O_IDLE);
        exp_q.push_back(O_ADDR);
        if (!is_rd) exp_q.push_back(O_WDATA);
        for (int i = 0; i < n_mem; i++) exp_q.push_back(is_rd ? O_MEMR : O_MEMW);
        if (rst_at < 0) begin
            if (!ok)        exp_q.push_back(O_ERR);
            else if (is_rd) begin
                exp_q.push_back(O_CAPT);
                exp_q.push_back(O_DONER);
            end else        exp_q.push_back(O_DONEW);
        end
        len = exp_q.size();

        start_rd = rd;
        start_wr = wr;
        for (int t = 1; t < len; t++) begin
            @(posedge clk); #1;
            start_rd  = 1'b0;
            start_wr  = (wr_mem >= 0) && (t - base == wr_mem);
            mem_ready = (rdy_at >= 0) && (t - base >= rdy_at);
            clr       = !((rst_at >= 0) && (t - base == rst_at));
        end
        @(posedge clk); #1;
        start_wr  = 1'b0;
        mem_ready = 1'b0;
        clr       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0; start_rd = 1'b0; start_wr = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("rst_busy", {8'd0, busy}, 9'd0);
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        run_xfer(1, 0, 0, -1, -1);    // read, ready from first MEM cycle: 2 MEM cycles
        run_xfer(0, 1, 4, -1, -1);    // write, ready on 5th MEM cycle
        run_xfer(1, 0, -1, -1, -1);   // read timeout: 16 MEM cycles then ERR
        run_xfer(1, 0, 15, -1, -1);   // ready on last allowed cycle: success wins
        run_xfer(1, 1, 2, -1, -1);    // both starts: read only
        run_xfer(1, 0, 6, 1, -1);     // stray start_wr during MEM ignored
        run_xfer(0, 1, -1, -1, -1);   // write timeout
        run_xfer(1, 0, -1, -1, 2);    // reset on 3rd MEM cycle
        run_xfer(0, 1, 0, -1, -1);    // write, ready early, MIN_WAIT honoured

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
